// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush/sequencing controls out.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_W = 3
) ();

   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use1;
   logic             id_use2;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             int_req;
   logic             mem_busy;

   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [1:0]       pc_sel;
   logic             push_sel;
   logic             push_en;
   logic             int_ack;
   logic             busy;

   // Pipeline side: reports status, consumes controls.
   modport master (
      output id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd, ex_branch_taken,
             int_req, mem_busy,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel, push_sel, push_en,
             int_ack, busy
   );

   // Controller side.
   modport slave (
      input  id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd, ex_branch_taken,
             int_req, mem_busy,
      output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel, push_sel, push_en,
             int_ack, busy
   );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, memory busy
// and the multi-cycle interrupt entry sequence (drain, push PC/flags, jump to vector).
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W      = 3,
   parameter int unsigned INT_CYCLES = 2
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      StRun,
      StIntDrain,
      StIntPush,
      StIntJump
   } state_e;

   localparam logic [2:0] CntLast = 3'(INT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   logic [REG_W-1:0] rs1, rs2, rd;
   logic             load_use;

   assign rs1 = hz.id_rs1;
   assign rs2 = hz.id_rs2;
   assign rd  = hz.ex_rd;

   assign load_use = hz.ex_mem_read &&
                     ((hz.id_use1 && (rs1 == rd)) || (hz.id_use2 && (rs2 == rd)));

   // State and push counter; synchronous reset abandons any interrupt sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and all control outputs, combinational from state and inputs.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hz.pc_stall    = 1'b0;
      hz.if_id_stall = 1'b0;
      hz.if_id_flush = 1'b0;
      hz.id_ex_flush = 1'b0;
      hz.pc_sel      = 2'd0;
      hz.push_sel    = 1'b0;
      hz.push_en     = 1'b0;
      hz.int_ack     = 1'b0;
      hz.busy        = 1'b0;

      if (!reset) begin
         unique case (state_q)
            StRun: begin
               // mem_busy outranks every RUN decision; the branch or request is
               // still presented next cycle since execute is held too.
               if (hz.mem_busy) begin
                  // stalls applied below
               end else if (hz.ex_branch_taken) begin
                  hz.pc_sel      = 2'd1;
                  hz.if_id_flush = 1'b1;
                  hz.id_ex_flush = 1'b1;
               end else if (hz.int_req) begin
                  hz.pc_stall    = 1'b1;
                  hz.if_id_flush = 1'b1;
                  state_d        = StIntDrain;
               end else if (load_use) begin
                  hz.pc_stall    = 1'b1;
                  hz.if_id_stall = 1'b1;
                  hz.id_ex_flush = 1'b1;
               end
            end
            StIntDrain: begin
               hz.busy        = 1'b1;
               hz.pc_stall    = 1'b1;
               hz.if_id_flush = 1'b1;
               hz.id_ex_flush = 1'b1;
               if (!hz.mem_busy) begin
                  state_d = StIntPush;
                  cnt_d   = '0;
               end
            end
            StIntPush: begin
               hz.busy        = 1'b1;
               hz.push_en     = 1'b1;
               hz.push_sel    = (cnt_q != 3'd0);
               hz.pc_stall    = 1'b1;
               hz.if_id_flush = 1'b1;
               hz.id_ex_flush = 1'b1;
               if (!hz.mem_busy) begin
                  if (cnt_q == CntLast) begin
                     state_d = StIntJump;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            StIntJump: begin
               hz.busy        = 1'b1;
               hz.if_id_flush = 1'b1;
               // Vector is taken only on the cycle the PC actually moves, so the
               // ack stays a single pulse even if memory holds us here.
               if (!hz.mem_busy) begin
                  hz.pc_sel  = 2'd2;
                  hz.int_ack = 1'b1;
                  state_d    = StRun;
               end
            end
         endcase

         if (hz.mem_busy) begin
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a sequence-step reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned REG_W      = 3;
   localparam int unsigned INT_CYCLES = 2;

   logic clk = 1'b0;
   logic reset;

   pipe_hazard_ctrl_if #(.REG_W(REG_W)) hz ();

   pipe_hazard_ctrl #(
      .REG_W     (REG_W),
      .INT_CYCLES(INT_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (hz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model position in the interrupt sequence, counted in cycles since entry:
   // 0 running, 1 drain, 2..INT_CYCLES+1 push slots, INT_CYCLES+2 jump.
   int step_no = 0;

   // Output vector: pc_stall if_id_stall if_id_flush id_ex_flush pc_sel[1:0]
   //                push_sel push_en int_ack busy
   function automatic logic [9:0] dut_vec();
      return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_flush, hz.pc_sel,
              hz.push_sel, hz.push_en, hz.int_ack, hz.busy};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
      end
   endtask

   // Reference model: compare on the falling edge (inputs stable until the next rise),
   // then advance the model as the coming rising edge will.
   always @(negedge clk) begin
      logic       st, ist, ifl, xfl, psel, pen, ack, bsy, lu;
      logic [1:0] sel;
      int         nxt;
      st = 0; ist = 0; ifl = 0; xfl = 0; psel = 0; pen = 0; ack = 0; bsy = 0;
      sel = 2'd0;
      nxt = step_no;
      lu = hz.ex_mem_read && ((hz.id_use1 && hz.id_rs1 == hz.ex_rd) ||
                              (hz.id_use2 && hz.id_rs2 == hz.ex_rd));
      if (reset) begin
         nxt = 0;
      end else begin
         if (step_no == 0) begin
            if (hz.mem_busy) begin
            end else if (hz.ex_branch_taken) begin
               sel = 2'd1; ifl = 1; xfl = 1;
            end else if (hz.int_req) begin
               st = 1; ifl = 1; nxt = 1;
            end else if (lu) begin
               st = 1; ist = 1; xfl = 1;
            end
         end else if (step_no <= INT_CYCLES + 1) begin
            bsy = 1; st = 1; ifl = 1; xfl = 1;
            if (step_no >= 2) begin
               pen  = 1;
               psel = (step_no != 2);
            end
            if (!hz.mem_busy) nxt = step_no + 1;
         end else begin
            bsy = 1; ifl = 1;
            if (!hz.mem_busy) begin
               sel = 2'd2; ack = 1; nxt = 0;
            end
         end
         if (hz.mem_busy) begin
            st = 1; ist = 1;
         end
      end
      check($sformatf("model step=%0d", step_no), dut_vec(),
            {st, ist, ifl, xfl, sel, psel, pen, ack, bsy});
      step_no = nxt;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.id_rs1          = '0;
      hz.id_rs2          = '0;
      hz.id_use1         = 1'b0;
      hz.id_use2         = 1'b0;
      hz.ex_mem_read     = 1'b0;
      hz.ex_rd           = '0;
      hz.ex_branch_taken = 1'b0;
      hz.int_req         = 1'b0;
      hz.mem_busy        = 1'b0;
   endtask

   initial begin
      int n;
      // Reset with every request active: all outputs must be zero.
      reset              = 1'b1;
      hz.id_rs1          = 3'd3;
      hz.id_rs2          = 3'd3;
      hz.id_use1         = 1'b1;
      hz.id_use2         = 1'b1;
      hz.ex_mem_read     = 1'b1;
      hz.ex_rd           = 3'd3;
      hz.ex_branch_taken = 1'b1;
      hz.int_req         = 1'b1;
      hz.mem_busy        = 1'b1;
      #1 check("reset_outputs", dut_vec(), 10'b0000_00_0000);
      step();
      step();
      reset = 1'b0;
      idle();
      #1 check("idle_after_reset", dut_vec(), 10'b0000_00_0000);
      step();

      // Load-use through rs2, then the load has moved on.
      hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd3; hz.id_rs2 = 3'd3; hz.id_use2 = 1'b1;
      #1 check("load_use_rs2", dut_vec(), 10'b1101_00_0000);
      step();
      hz.ex_mem_read = 1'b0;
      #1 check("load_use_cleared", dut_vec(), 10'b0000_00_0000);
      step();
      hz.ex_mem_read = 1'b1; hz.id_use2 = 1'b0;
      #1 check("load_use_not_read", dut_vec(), 10'b0000_00_0000);
      step();
      hz.id_use2 = 1'b1; hz.ex_rd = 3'd4;
      #1 check("load_use_other_rd", dut_vec(), 10'b0000_00_0000);
      step();

      // Taken branch overrides a simultaneous load-use.
      hz.ex_rd = 3'd3; hz.ex_branch_taken = 1'b1;
      #1 check("branch_over_load_use", dut_vec(), 10'b0011_01_0000);
      step();
      idle();

      // Interrupt held high through the whole sequence.
      hz.int_req = 1'b1;
      #1 check("int_run_entry", dut_vec(), 10'b1010_00_0000);
      step();
      #1 check("int_drain", dut_vec(), 10'b1011_00_0001);
      step();
      #1 check("int_push_pc", dut_vec(), 10'b1011_00_0101);
      step();
      #1 check("int_push_flags", dut_vec(), 10'b1011_00_1101);
      step();
      #1 check("int_jump", dut_vec(), 10'b0010_10_0011);
      step();
      #1 check("int_reenter", dut_vec(), 10'b1010_00_0000);
      step();
      hz.int_req = 1'b0;
      n = 0;
      while (hz.busy && n < 20) begin
         step();
         n++;
      end
      check("reentry_len", 10'(n), 10'd4);

      // mem_busy for three cycles in the first push slot.
      hz.int_req = 1'b1;
      step();
      hz.int_req = 1'b0;
      step();
      hz.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("push_pc_mem_busy", dut_vec(), 10'b1111_00_0101);
         step();
      end
      hz.mem_busy = 1'b0;
      #1 check("push_pc_resume", dut_vec(), 10'b1011_00_0101);
      step();
      #1 check("push_flags_resume", dut_vec(), 10'b1011_00_1101);
      step();
      #1 check("jump_resume", dut_vec(), 10'b0010_10_0011);
      step();
      #1 check("run_after_busy_seq", dut_vec(), 10'b0000_00_0000);
      step();

      // Reset during the push phase abandons the sequence.
      hz.int_req = 1'b1;
      step();
      hz.int_req = 1'b0;
      step();
      reset = 1'b1;
      #1 check("reset_in_push", dut_vec(), 10'b0000_00_0000);
      step();
      reset = 1'b0;
      #1 check("run_after_reset", dut_vec(), 10'b0000_00_0000);
      step();

      // Randomized traffic; the model process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         reset              = ($urandom_range(0, 99) < 2);
         hz.mem_busy        = ($urandom_range(0, 99) < 20);
         hz.ex_branch_taken = ($urandom_range(0, 99) < 15);
         hz.int_req         = ($urandom_range(0, 99) < 10);
         hz.ex_mem_read     = ($urandom_range(0, 99) < 50);
         hz.id_use1         = 1'($urandom_range(0, 1));
         hz.id_use2         = 1'($urandom_range(0, 1));
         hz.id_rs1          = REG_W'($urandom_range(0, 3));
         hz.id_rs2          = REG_W'($urandom_range(0, 3));
         hz.ex_rd           = REG_W'($urandom_range(0, 3));
         step();
      end

      reset = 1'b0;
      idle();
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage processor. It generates the stall and flush controls for the PC, the fetch/decode register and the decode/execute register. It resolves three hazard classes: load-use data hazards, taken-branch control hazards and external interrupt entry. It also handles stalls while data memory is busy. It owns a small FSM for the multi-cycle interrupt entry sequence; all other decisions are single-cycle.

## Interface
- REG_W, 3, register-index width
- INT_CYCLES, 2, cycles spent pushing PC/flags during interrupt entry (1..7)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1  in  REG_W  source register 1 of the instruction in decode
- id_rs2  in  REG_W  source register 2 of the instruction in decode
- id_use1  in  1  decode instruction reads rs1
- id_use2  in  1  decode instruction reads rs2
- ex_mem_read  in  1  instruction in execute is a load
- ex_rd  in  REG_W  destination of the instruction in execute
- ex_branch_taken  in  1  execute resolved a taken branch/jump this cycle
- int_req  in  1  level interrupt request
- mem_busy  in  1  data memory cannot complete this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold fetch/decode register
- if_id_flush  out  1  load NOP bubble into fetch/decode register
- id_ex_flush  out  1  load NOP bubble into decode/execute register
- pc_sel  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = interrupt vector
- push_sel  out  1  during interrupt entry: 0 = push PC, 1 = push flags
- push_en  out  1  memory-stage push of PC/flags active
- int_ack  out  1  one-cycle pulse when the vector is taken
- busy  out  1  FSM not in RUN

## Operation
- FSM states: RUN, INT_DRAIN, INT_PUSH, INT_JUMP. Encoding is free; only behaviour is specified.
- All outputs are combinational from state and inputs. State and push counter are registered.
- Load-use hazard (RUN) when ex_mem_read=1 and ((id_use1 and id_rs1==ex_rd) or (id_use2 and id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle.
  - No state change; the load advances, so the condition clears on the next cycle.
- Taken branch (RUN, ex_branch_taken=1): pc_sel=1, if_id_flush=1, id_ex_flush=1. The load-use stall is suppressed that cycle.
- mem_busy=1 in any state: pc_stall=1, if_id_stall=1; the FSM and push counter freeze.
  - Flushes requested in the same cycle still assert; flush beats stall at the register.
- Interrupt entry:
  - RUN with int_req=1, no taken branch and no mem_busy: go to INT_DRAIN. Set pc_stall=1 and if_id_flush=1 (stop fetching).
  - INT_DRAIN lasts one cycle with pc_stall=1, if_id_flush=1, id_ex_flush=1. It then goes to INT_PUSH with counter=0.
  - INT_PUSH: push_en=1, pc_stall=1, if_id_flush=1, id_ex_flush=1. push_sel=0 when counter==0, else 1. Counter increments each non-busy cycle; at INT_CYCLES-1 go to INT_JUMP.
  - INT_JUMP: pc_sel=2, int_ack=1, if_id_flush=1, then go to RUN.
  - int_req is ignored outside RUN. A request held high re-enters only after returning to RUN.
- Priority in RUN: reset > mem_busy > ex_branch_taken > int_req > load-use.
- A branch and an interrupt in the same cycle: the branch is taken and the interrupt is sampled the next cycle.
- Outputs with no condition active: 0, with pc_sel=0.

## Timing
- Reset: when reset=1 at a clock edge, state=RUN and counter=0. While reset is high, every output is 0 and pc_sel=0.
- Reset mid-interrupt abandons the sequence; int_ack is not issued.
- Load-use costs 1 bubble. A taken branch costs 2 flushed slots.
- Interrupt entry latency, with no mem_busy: 1 (DRAIN) + INT_CYCLES (PUSH) + 1 (JUMP) cycles from the first RUN cycle with int_req=1.
  - With INT_CYCLES=2, int_ack is high in the 4th cycle after int_req is sampled.
- busy=1 in every state other than RUN.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_use2=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1. Next cycle with ex_mem_read=0 -> all 0.
- Same as above but id_use2=0, or ex_rd=4 -> no stall.
- Taken branch together with a load-use match -> pc_sel=1, if_id_flush=id_ex_flush=1, if_id_stall=0.
- Interrupt, INT_CYCLES=2, int_req held high -> busy=1 for 4 cycles.
  - push_en high in cycles 2–3 with push_sel 0 then 1; pc_sel=2 and int_ack=1 in cycle 4; RUN in cycle 5.
- mem_busy=1 for 3 cycles during INT_PUSH (counter=0) -> counter and state hold, stalls asserted. The sequence then completes with total latency +3.
- Reset asserted in INT_PUSH -> next cycle state=RUN, all outputs 0, no int_ack pulse.
